// File: rtl/uart_pkg.sv
// Shared UART definitions: word width, frame size, FSM encoding and parity helper.
package uart_pkg;
  localparam int DATA_WIDTH = 7;
  // start + parity + data bits; stop bits are added per instance
  localparam int FRAME_BITS = DATA_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, START, PARITY, DATA, STOP} state_t;

  typedef struct packed {
    logic                  par;
    logic [DATA_WIDTH-1:0] data;
  } shift_t;

  function automatic logic parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter; bit_end marks the last clock of each serial bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);
  localparam int            CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                        cnt <= '0;
    else if (restart || cnt == '0)  cnt <= TOP;
    else                            cnt <= cnt - CW'(1);
  end

  assign bit_end = (cnt == '0);
endmodule

// File: rtl/uart_transmitter.sv
// 7-bit UART transmitter: start, parity, LSB-first data, STOP_BITS stop bits,
// with a one-word holding buffer so frames can run back-to-back.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);
  localparam logic [2:0] LAST_IDX  = 3'(DATA_WIDTH - 1);
  localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

  state_t                state, state_nx;
  shift_t                shf, shf_nx;
  logic [2:0]            bit_idx, bit_idx_nx;
  logic [1:0]            stop_cnt, stop_cnt_nx;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  bit_end, accept, last_stop, load_buf, load, tx_d;
  logic [DATA_WIDTH-1:0] load_word;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (load),
    .bit_end (bit_end)
  );

  assign accept    = data_valid & ~buf_full;
  assign last_stop = (state == STOP) & bit_end & (stop_cnt == LAST_STOP);
  // Buffered word goes out from IDLE or straight after the last stop cycle.
  assign load_buf  = buf_full & ((state == IDLE) | last_stop);
  assign load      = load_buf | ((state == IDLE) & accept);
  assign load_word = load_buf ? buf_data : data_in;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = START;
      START:   if (bit_end) state_nx = PARITY;
      PARITY:  if (bit_end) state_nx = DATA;
      DATA:    if (bit_end && bit_idx == LAST_IDX) state_nx = STOP;
      STOP:    if (last_stop) state_nx = load ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    shf_nx      = shf;
    bit_idx_nx  = bit_idx;
    stop_cnt_nx = stop_cnt;
    if (load) begin
      shf_nx.par  = parity(load_word, PARITY_ODD);
      shf_nx.data = load_word;
      bit_idx_nx  = '0;
      stop_cnt_nx = '0;
    end else if (bit_end) begin
      case (state)
        DATA: if (bit_idx != LAST_IDX) begin
          shf_nx.data = shf.data >> 1;
          bit_idx_nx  = bit_idx + 3'd1;
        end
        STOP:    stop_cnt_nx = stop_cnt + 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shf      <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
      buf_full <= 1'b0;
      buf_data <= '0;
      tx       <= 1'b1;
    end else begin
      shf      <= shf_nx;
      bit_idx  <= bit_idx_nx;
      stop_cnt <= stop_cnt_nx;
      tx       <= tx_d;
      if (load_buf) begin
        buf_full <= 1'b0;
      end else if (accept && state != IDLE) begin
        buf_full <= 1'b1;
        buf_data <= data_in;
      end
    end
  end

  // tx is registered from next-cycle state so the start bit follows the load edge.
  always_comb begin
    case (state_nx)
      START:   tx_d = 1'b0;
      PARITY:  tx_d = shf_nx.par;
      DATA:    tx_d = shf_nx.data[0];
      default: tx_d = 1'b1;
    endcase
    data_ready = ~buf_full;
    busy       = (state != IDLE) | buf_full;
    frame_done = last_stop;
  end
endmodule
